// File: rtl/mlp_div_seq_16s.sv
`default_nettype none
// ============================================================================
// Module   : mlp_div_seq_16s
// Purpose  : Sequential signed fixed-point divider for the MLP datapath.
//            Computes (din0 << FRAC_BITS) / din1 and its remainder using
//            radix-2 restoring division on magnitudes, one quotient bit per
//            enabled clock. Signs are applied and the quotient saturated in
//            a final fix-up cycle.
// Ports    : clk         - clock, rising edge
//            reset       - synchronous active-high reset (beats ce)
//            ce          - clock enable for every register
//            start/ready - request handshake; accepted on start&ready&ce
//            din0/din1   - signed dividend / divisor, sampled on accept
//            dout        - signed quotient, truncated toward zero, saturated
//            rem_out     - signed remainder, sign of dividend, 0 if saturated
//            out_vld     - single-cycle result strobe
//            div_by_zero - divisor was zero (held until next accept)
//            overflow    - quotient saturated (held until next accept)
// Revision : 1.0 - initial release
// ============================================================================
module mlp_div_seq_16s #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  out_vld,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int c_n  = DATA_WIDTH + FRAC_BITS;
    localparam int c_cw = $clog2(c_n);

    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_n - 1);

    // Quotient magnitude limits: 2^(W-1) is representable only as a negative.
    localparam logic [c_n-1:0] c_neg_lim = {{(c_n-1){1'b0}}, 1'b1} << (DATA_WIDTH-1);
    localparam logic [c_n-1:0] c_pos_lim = c_neg_lim - 1'b1;

    localparam logic [DATA_WIDTH-1:0] c_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    // r_dvd starts as the shifted dividend magnitude; quotient bits enter at
    // the LSB as dividend bits leave at the MSB, so after c_n iterations it
    // holds the quotient magnitude.
    logic [c_n-1:0]        r_dvd;
    logic [DATA_WIDTH-1:0] r_dsr;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [c_cw-1:0]       r_cnt;
    logic                  r_sgn0;
    logic                  r_sgn1;

    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] r_rem_out;
    logic                  r_vld;
    logic                  r_dbz;
    logic                  r_ovf;

    logic [DATA_WIDTH-1:0] w_abs0;
    logic [DATA_WIDTH-1:0] w_abs1;
    logic [DATA_WIDTH:0]   w_shift;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_q_neg;
    logic                  w_q_ovf;
    logic                  w_dbz;
    logic [DATA_WIDTH-1:0] w_q_lo;
    logic [DATA_WIDTH-1:0] w_q_signed;
    logic [DATA_WIDTH-1:0] w_rem_signed;

    // Magnitudes as unsigned DATA_WIDTH values: |-2^(W-1)| = 2^(W-1) is exact.
    assign w_abs0 = din0[DATA_WIDTH-1] ? (~din0 + 1'b1) : din0;
    assign w_abs1 = din1[DATA_WIDTH-1] ? (~din1 + 1'b1) : din1;

    // One restoring step. The partial remainder is always below the divisor,
    // so the subtraction result fits DATA_WIDTH bits whenever it is kept.
    assign w_shift = {r_rem, r_dvd[c_n-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});
    assign w_diff  = w_shift[DATA_WIDTH-1:0] - r_dsr;

    // Fix-up: a zero divisor magnitude means a zero divisor.
    assign w_dbz        = (r_dsr == '0);
    assign w_q_neg      = r_sgn0 ^ r_sgn1;
    assign w_q_ovf      = w_q_neg ? (r_dvd > c_neg_lim) : (r_dvd > c_pos_lim);
    assign w_q_lo       = r_dvd[DATA_WIDTH-1:0];
    assign w_q_signed   = w_q_neg ? (~w_q_lo + 1'b1) : w_q_lo;
    assign w_rem_signed = r_sgn0 ? (~r_rem + 1'b1) : r_rem;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = (din1 == '0) ? c_st_fix : c_st_calc;
                end
            end
            c_st_calc: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_fix;
                end
            end
            c_st_fix:  w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sgn0    <= 1'b0;
            r_sgn1    <= 1'b0;
            r_dout    <= '0;
            r_rem_out <= '0;
            r_vld     <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (ce) begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_dvd  <= c_n'(w_abs0) << FRAC_BITS;
                        r_dsr  <= w_abs1;
                        r_sgn0 <= din0[DATA_WIDTH-1];
                        r_sgn1 <= din1[DATA_WIDTH-1];
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_dbz  <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                c_st_calc: begin
                    r_rem <= w_ge ? w_diff : w_shift[DATA_WIDTH-1:0];
                    r_dvd <= {r_dvd[c_n-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                c_st_fix: begin
                    r_vld <= 1'b1;
                    if (w_dbz) begin
                        r_dout    <= r_sgn0 ? c_min : c_max;
                        r_rem_out <= '0;
                        r_dbz     <= 1'b1;
                        r_ovf     <= 1'b0;
                    end else if (w_q_ovf) begin
                        r_dout    <= w_q_neg ? c_min : c_max;
                        r_rem_out <= '0;
                        r_ovf     <= 1'b1;
                    end else begin
                        r_dout    <= w_q_signed;
                        r_rem_out <= w_rem_signed;
                    end
                end
                c_st_done: begin
                    r_vld <= 1'b0;
                end
                default: begin
                    r_vld <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = (r_state == c_st_idle);
    assign dout        = r_dout;
    assign rem_out     = r_rem_out;
    assign out_vld     = r_vld;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire
